// File: rtl/seq_alu_if.sv
// Request/response bundle between a seq_alu and its producer/consumer.
// master drives requests and out_ready; slave is the ALU side.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             cout;
    logic             zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, r, cout, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, r, cout, zero
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU, one request at a time; optional shift-add multiplier under SEQ_ALU_MUL_EN.
// Latency 1 cycle (MUL: WIDTH+1); result holds in DONE until out_ready, in_ready only when IDLE.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic      clk,
    input  logic      rst,
    seq_alu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state;
    state_t state_nxt;

    logic             accept;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH-1:0] alu_r;
    logic             alu_c;
    logic             load_en;
    logic [WIDTH-1:0] r_load;
    logic             c_load;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign accept        = bus.in_valid && bus.in_ready;

`ifdef SEQ_ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic                 is_mul;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     mplier;
    logic                 mul_last;

    assign is_mul   = (bus.op == 3'b110);
    assign mul_last = (state == BUSY) && (cnt == CNT_LAST);
    assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

    // One multiplier bit consumed per BUSY cycle; the final partial sum lands in r directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (accept && is_mul) begin
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.a};
            mplier <= bus.b;
            acc    <= '0;
        end else if (state == BUSY) begin
            cnt    <= cnt + CW'(1);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            acc    <= acc_nxt;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef SEQ_ALU_MUL_EN
                    state_nxt = is_mul ? BUSY : DONE;
`else
                    state_nxt = DONE;
`endif
                end
            end
            BUSY: begin
`ifdef SEQ_ALU_MUL_EN
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
`else
                state_nxt = IDLE;
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle ops; 110 falls to the reserved default unless routed to the multiplier.
    always_comb begin
        add_full = {1'b0, bus.a} + {1'b0, bus.b};
        sub_full = {1'b0, bus.a} - {1'b0, bus.b};
        alu_r    = '0;
        alu_c    = 1'b0;
        case (bus.op)
            3'b000: begin
                alu_r = add_full[WIDTH-1:0];
                alu_c = add_full[WIDTH];
            end
            3'b001: begin
                alu_r = sub_full[WIDTH-1:0];
                alu_c = ~sub_full[WIDTH];
            end
            3'b010:  alu_r = bus.a & bus.b;
            3'b011:  alu_r = bus.a | bus.b;
            3'b100:  alu_r = bus.a ^ bus.b;
            3'b101:  alu_r = ~bus.a;
            default: alu_r = '0;
        endcase
    end

    always_comb begin
        load_en = 1'b0;
        r_load  = alu_r;
        c_load  = alu_c;
`ifdef SEQ_ALU_MUL_EN
        if (accept && !is_mul) begin
            load_en = 1'b1;
        end else if (mul_last) begin
            load_en = 1'b1;
            r_load  = acc_nxt[WIDTH-1:0];
            c_load  = |acc_nxt[2*WIDTH-1:WIDTH];
        end
`else
        load_en = accept;
`endif
    end

    // zero is derived from the exact value being loaded so it never lags r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.r    <= '0;
            bus.cout <= 1'b0;
            bus.zero <= 1'b0;
        end else if (load_en) begin
            bus.r    <= r_load;
            bus.cout <= c_load;
            bus.zero <= (r_load == '0);
        end
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; the block SHALL support any WIDTH from 4 to 32.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  request present on op/a/b.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT a, 110 MUL, 111 reserved.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand (ignored for NOT).
REQ-009 out_valid  output  1  r/cout/zero hold a result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 r  output  WIDTH  registered result.
REQ-012 cout  output  1  registered carry/no-borrow/overflow flag.
REQ-013 zero  output  1  registered flag, 1 when r equals 0.

Function
REQ-014 FSM states: IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Acceptance = in_valid && in_ready; op, a, b SHALL be captured at acceptance, and later input changes SHALL have no effect on that request.
REQ-016 in_valid outside IDLE SHALL be ignored and not queued.
REQ-017 Non-MUL ops: IDLE -> DONE on acceptance; out_valid SHALL rise exactly 1 cycle after acceptance.
REQ-018 ADD: r = (a+b) mod 2^WIDTH; cout = carry out of bit WIDTH-1.
REQ-019 SUB: r = (a-b) mod 2^WIDTH; cout = 1 when a >= b unsigned, else 0.
REQ-020 AND/OR/XOR/NOT: bitwise results; cout = 0.
REQ-021 Reserved op: r = 0, cout = 0, zero = 1; 1-cycle latency.
REQ-022 MUL: IDLE -> BUSY on acceptance; iterative shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY, then DONE; out_valid SHALL rise exactly WIDTH+1 cycles after acceptance.
REQ-023 MUL result: r = low WIDTH bits of the unsigned a*b; cout = 1 when the high WIDTH bits are nonzero.
REQ-024 DONE: r, cout, zero, out_valid SHALL hold stable until out_ready = 1; DONE -> IDLE on that cycle, and out_valid SHALL fall the next cycle.
REQ-025 out_ready outside DONE SHALL have no effect.
REQ-026 zero SHALL be computed from the same value loaded into r, in the same cycle.

Reset
REQ-027 While rst = 1: state IDLE, in_ready = 1, out_valid = 0, r = 0, cout = 0, zero = 0, and the MUL iteration counter cleared.
REQ-028 rst asserted in BUSY or DONE SHALL abandon the operation with no output; the first request after rst deasserts SHALL be accepted normally.

Configuration
REQ-029 Macro SEQ_ALU_MUL_EN defined: MUL is implemented per REQ-022/023.
REQ-030 Macro SEQ_ALU_MUL_EN undefined: op 110 SHALL behave as reserved (REQ-021), BUSY SHALL never be entered, and no multiplier datapath or counter logic SHALL be present.

Verification
REQ-031 WIDTH=16, ADD a=65280 b=257, out_ready=1 -> 1 cycle later out_valid=1, r=1, cout=1, zero=0.
REQ-032 SUB a=16 b=9 -> r=7, cout=1; then SUB a=9 b=16 -> r=65529, cout=0.
REQ-033 AND a=65280 b=255 -> r=0, zero=1, cout=0; OR a=43520 b=21760 -> r=65280, zero=0.
REQ-034 SEQ_ALU_MUL_EN defined, MUL a=300 b=300 -> in_ready=0 for the busy period, out_valid after exactly 17 cycles, r=24464, cout=1; with the macro undefined, the same stimulus -> r=0, zero=1 after 1 cycle.
REQ-035 ADD 3+4 with out_ready held 0 for 5 cycles -> r=7 and out_valid=1 stable, in_ready=0, a second in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-036 rst pulsed 8 cycles into a MUL -> out_valid=0, r=0, in_ready=1; the following ADD 1+1 -> r=2 after 1 cycle.
